poly_voice_engine: RTL

Time-multiplexed N-voice synthesis core. It replaces the fixed 4-oscillator generator, 4-input mixer and single shared envelope with one block. Each voice has its own phase accumulator, waveform select and ADSR envelope. On every audio sample tick the block sweeps all voices sequentially on one fast clock and emits one saturated signed mix sample, which feeds the I2S transmitter and echo path.

---
 rtl/poly_voice_engine.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: time-multiplexed N-voice oscillator, ADSR and saturating mixer.
// Define POLY_VOICE_NOISE_EN to give wave 3 a shared 16-bit Galois LFSR noise source.
module poly_voice_engine #(
   parameter int BITSIZE   = 16,
   parameter int VOICES    = 8,
   parameter int PHASESIZE = 24
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_tick,
   input  logic [VOICES-1:0]           gate,
   input  logic                        cfg_we,
   input  logic [$clog2(VOICES)-1:0]   cfg_voice,
   input  logic [1:0]                  cfg_addr,
   input  logic [31:0]                 cfg_data,
   output logic signed [BITSIZE-1:0]   out,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        clip,
   output logic                        overrun
);
   localparam int VW = $clog2(VOICES);
   localparam int AW = BITSIZE + VW;
   localparam logic signed [BITSIZE-1:0] MAXP = BITSIZE'(2**(BITSIZE-1)-1);
   localparam logic signed [BITSIZE-1:0] MINN = ~MAXP;
   localparam logic signed [AW-1:0] AMAX = AW'(2**(BITSIZE-1)-1);
   localparam logic signed [AW-1:0] AMIN = ~AMAX;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VOICE, S_SAT} state_t;
   typedef enum logic [2:0] {E_IDLE, E_ATT, E_DEC, E_SUS, E_REL} env_t;

   state_t                     state_q, state_d;
   logic [VW-1:0]              v_q, v_d;
   logic                       ph_q, ph_d;
   logic [PHASESIZE-1:0]       freq_sh_q [VOICES], freq_sh_d [VOICES], freq_q [VOICES], freq_d [VOICES];
   logic [31:0]                adsr_sh_q [VOICES], adsr_sh_d [VOICES], adsr_q [VOICES], adsr_d [VOICES];
   logic [1:0]                 wsel_sh_q [VOICES], wsel_sh_d [VOICES], wsel_q [VOICES], wsel_d [VOICES];
   logic [PHASESIZE-1:0]       phase_q [VOICES], phase_d [VOICES];
   logic [15:0]                amp_q [VOICES], amp_d [VOICES];
   env_t                       env_q [VOICES], env_d [VOICES];
   logic [VOICES-1:0]          gate_s_q, gate_s_d, gate_p_q, gate_p_d;
   logic signed [BITSIZE-1:0]  wave_q, wave_d, out_q, out_d, noise;
   logic signed [AW-1:0]       acc_q, acc_d;
   logic                       out_valid_q, out_valid_d, clip_q, clip_d, overrun_q, overrun_d;

   logic [PHASESIZE-1:0]       p;
   logic [BITSIZE-1:0]         pt;
   logic [BITSIZE-2:0]         tri_t;
   logic signed [BITSIZE+16:0] prod;
   logic [16:0]                ainc, sum, dn, rn;
   logic [15:0]                dstep, rstep, sus;
   logic                       rise, a_sat, d_hit, r_hit;
   env_t                       es;

`ifdef POLY_VOICE_NOISE_EN
   logic [15:0] lfsr_q, lfsr_d, lfsr_n;
   always_comb begin
      lfsr_n = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      lfsr_d = (state_q == S_VOICE && !ph_q && wsel_q[v_q] == 2'd3) ? lfsr_n : lfsr_q;
      noise = BITSIZE'($signed(lfsr_n));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 16'hACE1;
      else lfsr_q <= lfsr_d;
   end
`else
   assign noise = '0;
`endif

   always_comb begin
      state_d = state_q;
      v_d = v_q;
      ph_d = ph_q;
      freq_sh_d = freq_sh_q;
      adsr_sh_d = adsr_sh_q;
      wsel_sh_d = wsel_sh_q;
      freq_d = freq_q;
      adsr_d = adsr_q;
      wsel_d = wsel_q;
      phase_d = phase_q;
      amp_d = amp_q;
      env_d = env_q;
      gate_s_d = gate_s_q;
      gate_p_d = gate_p_q;
      wave_d = wave_q;
      acc_d = acc_q;
      out_d = out_q;
      out_valid_d = 1'b0;
      clip_d = 1'b0;
      overrun_d = overrun_q | (sample_tick && state_q != S_IDLE);
      p = phase_q[v_q] + freq_q[v_q];
      pt = p[PHASESIZE-1 -: BITSIZE];
      tri_t = pt[BITSIZE-1] ? ~pt[BITSIZE-2:0] : pt[BITSIZE-2:0];
      prod = wave_q * $signed({1'b0, amp_q[v_q]});
      sus = {adsr_q[v_q][15:8], 8'h00};
      ainc = 17'({1'b0, adsr_q[v_q][31:24]} + 9'd1) << 4;
      dstep = 16'({1'b0, adsr_q[v_q][23:16]} + 9'd1) << 2;
      rstep = 16'({1'b0, adsr_q[v_q][7:0]} + 9'd1) << 2;
      sum = {1'b0, amp_q[v_q]} + ainc;
      dn = {1'b0, amp_q[v_q]} - {1'b0, dstep};
      rn = {1'b0, amp_q[v_q]} - {1'b0, rstep};
      a_sat = sum >= 17'h0FFFF;
      d_hit = dn[16] || dn[15:0] <= sus;
      r_hit = rn[16] || rn[15:0] == 16'h0000;
      rise = gate_s_q[v_q] & ~gate_p_q[v_q];
      es = rise ? E_ATT
         : (!gate_s_q[v_q] && env_q[v_q] inside {E_ATT, E_DEC, E_SUS}) ? E_REL
         : env_q[v_q];
      if (cfg_we && cfg_addr == 2'd0) freq_sh_d[cfg_voice] = cfg_data[PHASESIZE-1:0];
      if (cfg_we && cfg_addr == 2'd1) adsr_sh_d[cfg_voice] = cfg_data;
      if (cfg_we && cfg_addr == 2'd2) wsel_sh_d[cfg_voice] = cfg_data[1:0];
      case (state_q)
         S_IDLE: state_d = sample_tick ? S_LOAD : S_IDLE;
         S_LOAD: begin
            freq_d = freq_sh_q;
            adsr_d = adsr_sh_q;
            wsel_d = wsel_sh_q;
            gate_p_d = gate_s_q;
            gate_s_d = gate;
            acc_d = '0;
            v_d = '0;
            ph_d = 1'b0;
            state_d = S_VOICE;
         end
         S_VOICE: begin
            ph_d = ~ph_q;
            if (!ph_q) begin
               phase_d[v_q] = p;
               wave_d = wsel_q[v_q] == 2'd0 ? pt ^ MINN
                      : wsel_q[v_q] == 2'd1 ? (p[PHASESIZE-1] ? MINN : MAXP)
                      : wsel_q[v_q] == 2'd2 ? {tri_t, 1'b0} - MAXP
                      : noise;
            end else begin
               // mix uses the amplitude from before this sweep's envelope step
               acc_d = acc_q + AW'(prod >>> 16);
               amp_d[v_q] = es == E_ATT ? (a_sat ? 16'hFFFF : sum[15:0])
                          : es == E_DEC ? (d_hit ? sus : dn[15:0])
                          : es == E_SUS ? sus
                          : es == E_REL ? (r_hit ? 16'h0000 : rn[15:0])
                          : amp_q[v_q];
               env_d[v_q] = es == E_ATT ? (a_sat ? E_DEC : E_ATT)
                          : es == E_DEC ? (d_hit ? E_SUS : E_DEC)
                          : es == E_REL ? (r_hit ? E_IDLE : E_REL)
                          : es;
               v_d = v_q + VW'(1);
               state_d = v_q == VW'(VOICES-1) ? S_SAT : S_VOICE;
            end
         end
         default: begin
            out_d = acc_q > AMAX ? MAXP : acc_q < AMIN ? MINN : BITSIZE'(acc_q);
            clip_d = acc_q > AMAX || acc_q < AMIN;
            out_valid_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         v_q <= '0;
         ph_q <= 1'b0;
         freq_sh_q <= '{default: '0};
         adsr_sh_q <= '{default: '0};
         wsel_sh_q <= '{default: '0};
         freq_q <= '{default: '0};
         adsr_q <= '{default: '0};
         wsel_q <= '{default: '0};
         phase_q <= '{default: '0};
         amp_q <= '{default: '0};
         env_q <= '{default: E_IDLE};
         gate_s_q <= '0;
         gate_p_q <= '0;
         wave_q <= '0;
         acc_q <= '0;
         out_q <= '0;
         out_valid_q <= 1'b0;
         clip_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         v_q <= v_d;
         ph_q <= ph_d;
         freq_sh_q <= freq_sh_d;
         adsr_sh_q <= adsr_sh_d;
         wsel_sh_q <= wsel_sh_d;
         freq_q <= freq_d;
         adsr_q <= adsr_d;
         wsel_q <= wsel_d;
         phase_q <= phase_d;
         amp_q <= amp_d;
         env_q <= env_d;
         gate_s_q <= gate_s_d;
         gate_p_q <= gate_p_d;
         wave_q <= wave_d;
         acc_q <= acc_d;
         out_q <= out_d;
         out_valid_q <= out_valid_d;
         clip_q <= clip_d;
         overrun_q <= overrun_d;
      end
   end

   assign out = out_q;
   assign out_valid = out_valid_q;
   assign busy = state_q != S_IDLE;
   assign clip = clip_q;
   assign overrun = overrun_q;
endmodule
